// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions the raw push buttons into debounced levels,
// press/release pulses and auto-repeat pulses, one channel per button.

module btn_channel #(
    parameter int DB_CYCLES     = 20000,
    parameter int HOLD_CYCLES   = 500000,
    parameter int REPEAT_CYCLES = 100000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt,
    output logic held_long
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int HW  = $clog2(HOLD_CYCLES + 1);
    localparam int RW  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0]  RPT_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    logic [1:0]     sync_q;
    logic [DBW-1:0] db_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [RW-1:0]  rpt_cnt;
    state_t         state;

    logic differ;
    logic flip;
    logic rise;
    logic fall;

    // The accepted value flips on the cycle the run of differing
    // samples would reach its full length; rise/fall are that flip
    // seen from the old level, so pulses land with the new level.
    assign differ = sync_q[1] ^ level;
    assign flip   = differ && (db_cnt == DB_LAST);
    assign rise   = flip && !level;
    assign fall   = flip && level;

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    // Debounce counter, accepted level and the registered edge pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
            rel    <= 1'b0;
        end else begin
            press <= rise;
            rel   <= fall;
            if (!differ || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (flip) begin
                level <= ~level;
            end
        end
    end

    // Repeat FSM: wait out the hold time after a press, then pulse
    // periodically until the button is released.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            rpt_cnt   <= '0;
            rpt       <= 1'b0;
            held_long <= 1'b0;
        end else begin
            rpt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RPT;
                        hold_cnt  <= '0;
                        rpt_cnt   <= '0;
                        rpt       <= 1'b1;
                        held_long <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RPT: begin
                    if (fall) begin
                        state     <= IDLE;
                        rpt_cnt   <= '0;
                        held_long <= 1'b0;
                    end else if (rpt_cnt == RPT_LAST) begin
                        rpt_cnt <= '0;
                        rpt     <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    hold_cnt  <= '0;
                    rpt_cnt   <= '0;
                    held_long <= 1'b0;
                end
            endcase
        end
    end

endmodule

module btn_conditioner #(
    parameter int N_BTN         = 5,
    parameter int DB_CYCLES     = 20000,
    parameter int HOLD_CYCLES   = 500000,
    parameter int REPEAT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic [N_BTN-1:0] btn_long
);

    // One fully independent conditioner per button.
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_channel #(
            .DB_CYCLES     (DB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_ch (
            .clk       (clk),
            .resetn    (resetn),
            .raw       (btn_raw[g]),
            .level     (btn_level[g]),
            .press     (btn_press[g]),
            .rel       (btn_release[g]),
            .rpt       (btn_repeat[g]),
            .held_long (btn_long[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed scenarios plus random button traffic,
// compared every cycle against a sliding-window/elapsed-time model.

module tb_btn_conditioner;

    localparam int N    = 5;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic         clk = 1'b0;
    logic         resetn;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;
    logic [N-1:0] btn_long;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [N-1:0] e_level = '0;
    logic [N-1:0] e_press = '0;
    logic [N-1:0] e_rel   = '0;
    logic [N-1:0] e_rpt   = '0;
    logic [N-1:0] e_long  = '0;
    logic [15:0]  smp [N];
    int           age [N];
    logic         m_lv;
    logic         m_flip;

    btn_conditioner #(
        .N_BTN         (N),
        .DB_CYCLES     (DB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. smp holds the values sampled at each edge
    // (bit0 newest). The level flips when the DB samples taken two
    // or more edges ago all differ from it. Repeat/long follow from
    // the number of edges elapsed since the press.
    initial begin
        for (int c = 0; c < N; c++) begin
            smp[c] = '0;
            age[c] = 0;
        end
        forever begin
            @(posedge clk);
            if (!resetn) begin
                for (int c = 0; c < N; c++) begin
                    smp[c] = '0;
                    age[c] = 0;
                end
                e_level = '0;
                e_press = '0;
                e_rel   = '0;
                e_rpt   = '0;
                e_long  = '0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    m_lv   = e_level[c];
                    m_flip = 1'b1;
                    for (int k = 1; k <= DB; k++) begin
                        if (smp[c][k] == m_lv) m_flip = 1'b0;
                    end
                    e_press[c] = m_flip & ~m_lv;
                    e_rel[c]   = m_flip & m_lv;
                    m_lv       = m_lv ^ m_flip;
                    e_level[c] = m_lv;
                    if (e_press[c]) age[c] = 0;
                    else if (m_lv) age[c]++;
                    e_rpt[c]  = m_lv && !e_press[c] && age[c] >= HOLD
                                && ((age[c] - HOLD) % REP) == 0;
                    e_long[c] = m_lv && age[c] >= HOLD;
                    smp[c]    = {smp[c][14:0], btn_raw[c]};
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("level",   32'(btn_level),   32'(e_level));
                chk("press",   32'(btn_press),   32'(e_press));
                chk("release", 32'(btn_release), 32'(e_rel));
                chk("repeat",  32'(btn_repeat),  32'(e_rpt));
                chk("long",    32'(btn_long),    32'(e_long));
            end
        end
    end

    task automatic idle(input int n);
        btn_raw = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin : main
        int press_at;
        int rel_at;
        int nrpt;
        int nlong;
        int p1, p3, r1, r3;
        int run_left [N];

        btn_raw = '0;
        resetn  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level",  32'(btn_level),   32'd0);
        chk("rst_press",  32'(btn_press),   32'd0);
        chk("rst_repeat", 32'(btn_repeat),  32'd0);
        chk("rst_long",   32'(btn_long),    32'd0);
        resetn = 1'b1;
        chk_en = 1'b1;
        idle(5);

        // Clean hold on channel 0.
        press_at = -1; rel_at = -1; nrpt = 0;
        @(negedge clk); btn_raw[0] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 30) btn_raw[0] = 1'b0;
            if (btn_press[0] && press_at < 0) press_at = k;
            if (btn_release[0]) rel_at = k;
            if (btn_repeat[0]) nrpt++;
        end
        chk("s1_press_cyc", 32'(press_at), 32'd6);
        chk("s1_rel_cyc",   32'(rel_at),   32'd36);
        chk("s1_n_repeat",  32'(nrpt),     32'd7);
        idle(10);

        // Bounce then steady press.
        press_at = -1; rel_at = -1; nrpt = 0;
        @(negedge clk); btn_raw[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            btn_raw[0] = (k >= 8) ? 1'b1 : (((k / 2) % 2) == 0);
            if (btn_press[0]) begin
                nrpt++;
                if (press_at < 0) press_at = k;
            end
            if (btn_release[0]) rel_at = k;
        end
        chk("s2_press_cyc", 32'(press_at), 32'd14);
        chk("s2_n_press",   32'(nrpt),     32'd1);
        chk("s2_release",   32'(rel_at),   32'hffff_ffff);
        idle(30);

        // Short glitch on channel 2.
        nrpt = 0;
        @(negedge clk); btn_raw[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) btn_raw[2] = 1'b0;
            if (btn_level[2] | btn_press[2] | btn_release[2] | btn_repeat[2])
                nrpt++;
        end
        chk("s3_glitch_act", 32'(nrpt), 32'd0);
        idle(5);

        // Short tap on channel 4.
        press_at = -1; rel_at = -1; nrpt = 0; nlong = 0;
        @(negedge clk); btn_raw[4] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 8) btn_raw[4] = 1'b0;
            if (btn_press[4] && press_at < 0) press_at = k;
            if (btn_release[4]) rel_at = k;
            if (btn_repeat[4]) nrpt++;
            if (btn_long[4]) nlong++;
        end
        chk("s4_press_cyc", 32'(press_at), 32'd6);
        chk("s4_rel_cyc",   32'(rel_at),   32'd14);
        chk("s4_rpt_long",  32'(nrpt + nlong), 32'd0);
        idle(5);

        // Independent channels 1 and 3.
        p1 = -1; p3 = -1; r1 = -1; r3 = -1;
        @(negedge clk); btn_raw[1] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k == 5) btn_raw[3] = 1'b1;
            if (btn_press[1] && p1 < 0) p1 = k;
            if (btn_press[3] && p3 < 0) p3 = k;
            if (btn_repeat[1] && r1 < 0) r1 = k;
            if (btn_repeat[3] && r3 < 0) r3 = k;
        end
        chk("s5_press1", 32'(p1), 32'd6);
        chk("s5_press3", 32'(p3), 32'd11);
        chk("s5_rpt1",   32'(r1), 32'd16);
        chk("s5_rpt3",   32'(r3), 32'd21);
        idle(15);

        // Reset in the repeat phase with the button held.
        press_at = -1; r1 = -1;
        @(negedge clk); btn_raw[0] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (k == 20) begin
                #2 resetn = 1'b0;
                #1;
                chk("s6_rst_level",  32'(btn_level),   32'd0);
                chk("s6_rst_press",  32'(btn_press),   32'd0);
                chk("s6_rst_rel",    32'(btn_release), 32'd0);
                chk("s6_rst_repeat", 32'(btn_repeat),  32'd0);
                chk("s6_rst_long",   32'(btn_long),    32'd0);
            end
            if (k == 24) resetn = 1'b1;
            if (k > 24) begin
                if (btn_press[0] && press_at < 0) press_at = k;
                if (btn_repeat[0] && r1 < 0) r1 = k;
            end
        end
        chk("s6_press_cyc", 32'(press_at), 32'd30);
        chk("s6_rpt_cyc",   32'(r1),       32'd40);
        idle(15);

        // Random traffic on all channels with occasional resets.
        for (int c = 0; c < N; c++) run_left[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                if (run_left[c] == 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    if ($urandom_range(0, 3) == 0)
                        run_left[c] = $urandom_range(1, 5);
                    else
                        run_left[c] = $urandom_range(6, 60);
                end else begin
                    run_left[c]--;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 resetn = 1'b0;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                resetn = 1'b1;
            end
        end
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
